btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
Conditions the eight raw active-low board push-buttons before they reach the term-project top level. It provides three things per button: a two-flop synchroniser, an independent debounce counter, and edge detection. Outputs:
- a clean active-low level bus, drop-in for the top level's btn_sw input;
- one-cycle active-high press and release pulses, so the input unit sees exactly one event per physical press.

Parameters:
- N_BTN, 8, number of button channels.
- DB_TICKS, 250000, consecutive stable cycles required before a level change is accepted (5 ms at 50 MHz). Legal range is 2 or more; elaboration error below 2.
- DB_CNT_W, 18, debounce counter width; must satisfy 2^DB_CNT_W > DB_TICKS.
- REPEAT_DELAY, 25000000, cycles from the press pulse to the first auto-repeat pulse (optional feature only).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (optional feature only).
- REPEAT_MASK, 8'b0000_0011, channels allowed to auto-repeat (bits 0/1 = digit buttons).

Ports:
- CLK, in, 1, board clock.
- rst_n, in, 1, asynchronous active-low reset.
- btn_raw, in, N_BTN, raw pin levels, active-low, asynchronous to CLK.
- btn_clean, out, N_BTN, debounced level, active-low (1 = released).
- btn_press, out, N_BTN, one-cycle active-high pulse on each accepted press.
- btn_release, out, N_BTN, one-cycle active-high pulse on each accepted release.
- btn_held, out, N_BTN, active-high, equals ~btn_clean.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - synchroniser flops = all 1;
  - btn_clean = all 1;
  - btn_press, btn_release, btn_held = 0;
  - all counters = 0.
- Reset is released synchronously internally; btn_raw is ignored until the synchroniser refills. Reset mid-debounce discards the partial count.
- Synchroniser: s1 <= btn_raw; s2 <= s1, per bit.
- Per channel, let stable = btn_clean[i]:
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt < DB_TICKS-1: cnt <= cnt+1.
  - s2 != stable and cnt == DB_TICKS-1: stable <= s2; cnt <= 0.
    - Pulse btn_press[i] (if s2=0) or btn_release[i] (if s2=1) in the same registered cycle that btn_clean changes.
- Latency: raw edge sampled at edge 0 → btn_clean and the pulse change at edge DB_TICKS+2. All outputs are registered; there is no combinational path from btn_raw.
- Glitch/bounce shorter than DB_TICKS consecutive cycles: counter clears and there is no output change. Any bounce back to stable restarts the count from 0.
- Pulses are exactly 1 cycle wide. btn_press and btn_release are never both high on one channel.
- Channels are fully independent; simultaneous presses on several channels produce same-cycle pulses on each.
- Counters saturate logically; they never wrap, because cnt is cleared at DB_TICKS-1.

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined: for each channel with REPEAT_MASK[i]=1 that remains held, a per-channel repeat counter starts at the press pulse.
  - An extra btn_press pulse fires REPEAT_DELAY cycles after the initial press, then every REPEAT_PERIOD cycles.
  - Release, or a rst_n assertion, clears the counter immediately; no repeat pulse is generated in the release cycle.
  - Masked-off channels (next, reset) never repeat.
- Undefined: no repeat counters are synthesised; exactly one btn_press per accepted press; the REPEAT_* parameters are ignored.

Decomposition:
- Package btn_pkg holds:
  - channel index constants BTN_ZERO=0, BTN_ONE=1, BTN_NEXT=2, BTN_RST=3;
  - default tick constants DB_TICKS_DEF, REPEAT_DELAY_DEF, REPEAT_PERIOD_DEF;
  - the default REPEAT_MASK.
- Sub-module btn_debounce_ch covers one channel: synchroniser, debounce counter, edge pulses and optional repeat counter. The top instantiates it N_BTN times in a generate loop, passing REPEAT_MASK[i] as a parameter.

Test Plan:
(Bench parameters: DB_TICKS=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.)
- Reset check: hold rst_n=0 with btn_raw=8'h00. Required: btn_clean=8'hFF and press/release=0. Release reset, then drive btn_raw[0]=0 steady. Required: btn_clean[0]=0 and btn_press[0]=1 for one cycle at edge 6 after the first sampling edge.
- Bounce rejection: btn_raw[1] toggles 0,1,0,1 every 2 cycles, then stays 0. Required: a single btn_press[1] exactly 6 edges after the last toggle, and no pulse during bounce.
- Release: from held, btn_raw[2]=1 steady. Required: btn_release[2] is a one-cycle pulse and btn_clean[2]=1 at edge 6. A 3-cycle release glitch produces no pulse.
- Simultaneous events: btn_raw=8'hF0 in one cycle. Required: btn_press=8'h0F in the same single cycle.
- Async reset mid-count: assert rst_n=0 two cycles into a press count, release, keep the button low. Required: the press pulse occurs DB_TICKS+2 edges after reset release, not earlier.
- With BTN_AUTOREPEAT_EN, hold btn 0 and btn 2 for 30 cycles after the press. Required:
  - btn_press[0] at +0, +10, +13, +16, …, and stops on release;
  - btn_press[2] only at +0.
- Without the macro, the same hold yields a single pulse on each channel.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared constants for the push-button conditioner.
//   - channel index constants for the board buttons
//   - default debounce / auto-repeat tick counts (50 MHz board clock)
//   - default auto-repeat channel mask (the two digit buttons)
//   - cnt_width(): counter width able to hold 0..max_val
package btn_pkg;

    localparam int BTN_ZERO = 0;
    localparam int BTN_ONE  = 1;
    localparam int BTN_NEXT = 2;
    localparam int BTN_RST  = 3;

    localparam int N_BTN_DEF         = 8;
    localparam int DB_TICKS_DEF      = 250_000;     // 5 ms
    localparam int DB_CNT_W_DEF      = 18;
    localparam int REPEAT_DELAY_DEF  = 25_000_000;  // 500 ms
    localparam int REPEAT_PERIOD_DEF = 5_000_000;   // 100 ms

    // Only the digit buttons may auto-repeat; next/reset must not.
    localparam logic [N_BTN_DEF-1:0] REPEAT_MASK_DEF = 8'b0000_0011;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel.
//   Two-flop synchroniser -> debounce counter -> registered level and
//   one-cycle press/release pulses. With BTN_AUTOREPEAT_EN defined and
//   REPEAT_EN set, a held button also emits repeat press pulses.
// Ports:
//   CLK    in   board clock
//   rst_n  in   asynchronous active-low reset
//   raw    in   raw pin level, active-low, asynchronous to CLK
//   clean  out  debounced level, active-low (1 = released)
//   press  out  one-cycle pulse on accepted press (and on repeats)
//   rel    out  one-cycle pulse on accepted release
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DB_TICKS      = DB_TICKS_DEF,
    parameter int DB_CNT_W      = DB_CNT_W_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter bit REPEAT_EN     = 1'b0
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic press,
    output logic rel
);

    logic                s1, s2;
    logic                stable;
    logic [DB_CNT_W-1:0] db_cnt;
    logic                accept;
    logic                rpt_hit;

    // Level change is accepted on the DB_TICKS-th consecutive differing sample.
    assign accept = (s2 != stable) && (db_cnt == DB_CNT_W'(DB_TICKS - 1));

`ifdef BTN_AUTOREPEAT_EN
    if (REPEAT_EN) begin : g_rpt
        localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RPT_W   = cnt_width(RPT_MAX);

        logic [RPT_W-1:0] rpt_cnt;
        logic             rpt_first;
        logic             held_both;

        // Counting starts in the cycle the press pulse leaves the block and
        // stops as soon as the internal level reports release, so a repeat
        // can never coincide with the release pulse.
        assign held_both = ~stable & ~clean;
        assign rpt_hit   = held_both &&
                           (rpt_first ? (rpt_cnt == RPT_W'(REPEAT_DELAY - 1))
                                      : (rpt_cnt == RPT_W'(REPEAT_PERIOD - 1)));

        always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b1;
            end else if (!held_both) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b1;
            end else if (rpt_hit) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end else begin
                rpt_cnt   <= rpt_cnt + 1'b1;
            end
        end
    end else begin : g_no_rpt
        assign rpt_hit = 1'b0;
    end
`else
    logic unused_rpt;
    assign unused_rpt = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD), REPEAT_EN};
    assign rpt_hit    = 1'b0;
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            stable <= 1'b1;
            db_cnt <= '0;
            clean  <= 1'b1;
            press  <= 1'b0;
            rel    <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == stable) begin
                db_cnt <= '0;
            end else if (accept) begin
                stable <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            // Output stage: level and pulses leave together, one cycle after
            // the internal level flips.
            clean <= stable;
            press <= (clean & ~stable) | rpt_hit;
            rel   <= ~clean & stable;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: conditions the raw active-low board push-buttons.
//   Each channel is synchronised, debounced and edge-detected independently.
//   Optional auto-repeat on masked channels: define BTN_AUTOREPEAT_EN.
// Ports:
//   CLK          in   board clock
//   rst_n        in   asynchronous active-low reset
//   btn_raw      in   [N_BTN] raw pin levels, active-low, asynchronous
//   btn_clean    out  [N_BTN] debounced level, active-low (1 = released)
//   btn_press    out  [N_BTN] one-cycle pulse per accepted press
//   btn_release  out  [N_BTN] one-cycle pulse per accepted release
//   btn_held     out  [N_BTN] active-high held level (~btn_clean)
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int               N_BTN         = N_BTN_DEF,
    parameter int               DB_TICKS      = DB_TICKS_DEF,
    parameter int               DB_CNT_W      = DB_CNT_W_DEF,
    parameter int               REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int               REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = N_BTN'(REPEAT_MASK_DEF)
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_clean,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_held
);

    if (DB_TICKS < 2) begin : g_bad_db_ticks
        $error("btn_conditioner: DB_TICKS must be at least 2");
    end
    if ((64'd1 << DB_CNT_W) <= 64'(DB_TICKS)) begin : g_bad_db_cnt_w
        $error("btn_conditioner: DB_CNT_W too narrow for DB_TICKS");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DB_TICKS      (DB_TICKS),
            .DB_CNT_W      (DB_CNT_W),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .REPEAT_EN     (REPEAT_MASK[i])
        ) u_ch (
            .CLK   (CLK),
            .rst_n (rst_n),
            .raw   (btn_raw[i]),
            .clean (btn_clean[i]),
            .press (btn_press[i]),
            .rel   (btn_release[i])
        );
    end

    assign btn_held = ~btn_clean;

endmodule
